// File: rtl/time_to_digital_decoder.sv
// time_to_digital_decoder: measures t_in arrival delay after start as an N_BIT code (T_DEL clk per LSB).
// Optional accumulator of accepted codes enabled by defining MAC_ACC_EN.
`default_nettype none

module time_to_digital_decoder #(
  parameter int N_BIT       = 4,
  parameter int T_DEL       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACC_BIT     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               t_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [N_BIT-1:0]   code,
  output logic               ovf,
  output logic               busy
`ifdef MAC_ACC_EN
  ,
  input  logic               acc_clr,
  output logic [ACC_BIT-1:0] acc_out
`endif
);

  localparam int FULL  = (1 << N_BIT) * T_DEL;
  localparam int LAST  = FULL + SYNC_STAGES - 1;
  localparam int CYC_W = $clog2(LAST + 1);
  localparam int SUB_W = (T_DEL > 1) ? $clog2(T_DEL) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CYC_W-1:0]       cyc;
  logic [SUB_W-1:0]       sub;
  logic [N_BIT-1:0]       lsb;

  // Arrival seen at the synchronizer output on edge e corresponds to m = e - SYNC_STAGES;
  // sub/lsb are held for the first SYNC_STAGES edges so they equal m-1 at that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= '0;
      cyc       <= '0;
      sub       <= '0;
      lsb       <= '0;
      out_valid <= 1'b0;
      code      <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], t_in};
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARMED;
            busy  <= 1'b1;
            cyc   <= '0;
            sub   <= '0;
            lsb   <= '0;
            sync  <= '0;
          end
        end
        ARMED: begin
          if (sync[SYNC_STAGES-1]) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            code      <= lsb;
            ovf       <= 1'b0;
          end else if (cyc == CYC_W'(LAST)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            code      <= '1;
            ovf       <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
            if (cyc >= CYC_W'(SYNC_STAGES)) begin
              if (sub == SUB_W'(T_DEL - 1)) begin
                sub <= '0;
                lsb <= lsb + 1'b1;
              end else begin
                sub <= sub + 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_ACC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out <= '0;
    end else if (acc_clr) begin
      acc_out <= '0;
    end else if (state == HOLD && out_valid && out_ready) begin
      acc_out <= acc_out + ACC_BIT'(code);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_to_digital_decoder.sv
// Self-checking bench for time_to_digital_decoder: vector table, randomized model checks, corner sequences.
`default_nettype none

module tb_time_to_digital_decoder;

  localparam int N_BIT = 4, T_DEL = 4, SYNC_STAGES = 2, ACC_BIT = 12;
  localparam int FULL  = (1 << N_BIT) * T_DEL;
  localparam int MAXC  = (1 << N_BIT) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, t_in = 1'b0, out_ready = 1'b0;
  logic out_valid, ovf, busy;
  logic [N_BIT-1:0] code;
`ifdef MAC_ACC_EN
  logic acc_clr = 1'b0;
  logic [ACC_BIT-1:0] acc_out;
  int exp_acc = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  time_to_digital_decoder #(.N_BIT(N_BIT), .T_DEL(T_DEL), .SYNC_STAGES(SYNC_STAGES), .ACC_BIT(ACC_BIT)) dut (
    .clk(clk), .rst(rst), .start(start), .t_in(t_in), .out_ready(out_ready),
    .out_valid(out_valid), .code(code), .ovf(ovf), .busy(busy)
`ifdef MAC_ACC_EN
    , .acc_clr(acc_clr), .acc_out(acc_out)
`endif
  );

  always #50 clk = ~clk;

  typedef struct {
    int rise;
    int exp_code;
    int exp_ovf;
    int exp_edge;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: t_in rises before edge `rise` (<=0 means already high at start).
  function automatic void model(input int rise, output int c, output int o, output int e);
    int m;
    m = (rise < 1) ? 1 : rise;
    if (m <= FULL) begin
      c = (m - 1) / T_DEL;
      if (c > MAXC) c = MAXC;
      o = 0;
      e = m + SYNC_STAGES;
    end else begin
      c = MAXC;
      o = 1;
      e = FULL + SYNC_STAGES;
    end
  endfunction

  task automatic measure(input int rise, input int ready_dly, input int exp_code, input int exp_ovf,
                         input int exp_edge, input bit start_in_hold, input bit start_with_accept,
                         input bit clr_with_accept);
    int got;
    got = -1;
    t_in  = (rise <= 0);
    start = 1'b1;
    tick();                      // edge 0
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int e = 1; e <= FULL + SYNC_STAGES + 8; e++) begin
      if (e == rise) t_in = 1'b1;
      tick();
      if (out_valid) begin
        got = e;
        break;
      end
    end
    check("valid_edge", got, exp_edge);
    if (got < 0) begin
      rst = 1'b1; #10; rst = 1'b0; t_in = 1'b0;
      tick();
      return;
    end
    check("code", code, exp_code);
    check("ovf", ovf, exp_ovf);
    check("busy_in_hold", busy, 1);
    t_in = 1'b0;                 // glitch after arrival: must not matter
    for (int i = 0; i < ready_dly; i++) begin
      t_in  = i[0];
      start = start_in_hold && (i == 1);
      tick();
      start = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_code", code, exp_code);
    end
    t_in      = 1'b0;
    out_ready = 1'b1;
    start     = start_with_accept;
`ifdef MAC_ACC_EN
    acc_clr = clr_with_accept;
    exp_acc = clr_with_accept ? 0 : (exp_acc + exp_code) % (1 << ACC_BIT);
`endif
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
`ifdef MAC_ACC_EN
    acc_clr = 1'b0;
    check("acc_after_accept", acc_out, exp_acc);
`else
    if (clr_with_accept) check("clr_ignored_busy", busy, 0);
`endif
    check("valid_after_accept", out_valid, 0);
    check("busy_after_accept", busy, 0);
    check("code_held", code, exp_code);
    if (start_in_hold || start_with_accept) begin
      tick();
      check("start_ignored_busy", busy, 0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int c, o, e, r;
    vecs[0] = '{9,    2,  0, 11};
    vecs[1] = '{1000, 15, 1, 66};
    vecs[2] = '{0,    0,  0, 3};
    vecs[3] = '{4,    0,  0, 6};
    vecs[4] = '{5,    1,  0, 7};
    vecs[5] = '{61,   15, 0, 63};
    vecs[6] = '{64,   15, 0, 66};
    vecs[7] = '{65,   15, 1, 66};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_code", code, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
`ifdef MAC_ACC_EN
    check("rst_acc", acc_out, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      measure(vecs[i].rise, 1, vecs[i].exp_code, vecs[i].exp_ovf, vecs[i].exp_edge, 1'b0, 1'b0, 1'b0);

    // Back-pressure, start during HOLD, and start coincident with accept
    measure(9, 5, 2, 0, 11, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a measurement
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("armed_busy", busy, 1);
    #20 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    measure(13, 0, 3, 0, 15, 1'b0, 1'b0, 1'b0);

`ifdef MAC_ACC_EN
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    exp_acc = 0;
    check("acc_cleared", acc_out, 0);
    measure(9, 0, 2, 0, 11, 1'b0, 1'b0, 1'b0);
    measure(1000, 0, 15, 1, 66, 1'b0, 1'b0, 1'b0);
    measure(13, 0, 3, 0, 15, 1'b0, 1'b0, 1'b0);
    check("acc_sum_20", acc_out, 20);
    measure(21, 0, 5, 0, 23, 1'b0, 1'b0, 1'b1);
    check("acc_clr_priority", acc_out, 0);
`endif

    // Randomized arrivals against the reference model
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, FULL + 8);
      model(r, c, o, e);
      measure(r, $urandom_range(0, 3), c, o, e, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
